// File: rtl/cpu_pkg.sv
// Shared CPU memory geometry, opcode map and the RAM-arbiter state encoding.
package cpu_pkg;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {RUN, DRAIN, MANUAL, WRITE, CLEAR} ram_ctrl_state_t;
endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus stability counter; emits a debounced level and a
// one-cycle pulse on its rising edge.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync0, r_sync1, r_level, r_pulse;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the current level;
    // any agreeing sample restarts the count, so short glitches never flip it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
            r_pulse <= 1'b0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync1;
                r_pulse <= r_sync1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;
endmodule

// File: rtl/ram_program_controller.sv
// Arbitrates the CPU memory port between the running CPU and the front panel;
// manual control is only taken at an instruction boundary.
module ram_program_controller
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_sw,
    input  logic              step_btn,
    input  logic              write_btn,
    input  logic              clear_btn,
    input  logic [DATA_W-1:0] program_switches,
    input  logic              cpu_boundary,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    output logic              manual_mode,
    output logic [ADDR_W-1:0] prog_addr
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    ram_ctrl_state_t   r_state, w_next;
    logic [ADDR_W-1:0] r_prog_addr, r_sweep;
    logic              r_cpu_hold, r_manual_mode;
    logic [3:0]        w_raw, w_lvl, w_pls;
    logic              w_mode, w_step_p, w_wr_p, w_clr_p, w_unused;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;

    assign w_raw = {clear_btn, write_btn, step_btn, mode_sw};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_raw   (w_raw[g]),
            .o_level (w_lvl[g]),
            .o_pulse (w_pls[g])
        );
    end

    assign w_mode   = w_lvl[0];
    assign w_step_p = w_pls[1];
    assign w_wr_p   = w_pls[2];
    assign w_clr_p  = w_pls[3];
    assign w_unused = ^{w_pls[0], w_lvl[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:    if (w_mode) w_next = DRAIN;
            DRAIN:  if (!w_mode) w_next = RUN;
                    else if (cpu_boundary) w_next = MANUAL;
            MANUAL: if (w_clr_p) w_next = CLEAR;
                    else if (w_wr_p) w_next = WRITE;
                    else if (!w_step_p && !w_mode) w_next = RUN;
            WRITE:  w_next = MANUAL;
            CLEAR:  if (r_sweep == LAST_ADDR) w_next = MANUAL;
            default: w_next = RUN;
        endcase
    end

    // Hold/LED are derived from the next state so they move on the same edge
    // as the passthrough switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_addr   <= '0;
            r_sweep       <= '0;
            r_cpu_hold    <= 1'b0;
            r_manual_mode <= 1'b0;
        end else begin
            r_cpu_hold    <= (w_next == MANUAL) || (w_next == WRITE) || (w_next == CLEAR);
            r_manual_mode <= (w_next == MANUAL) || (w_next == WRITE) || (w_next == CLEAR);
            if (r_state == WRITE ||
                (r_state == MANUAL && w_step_p && !w_clr_p && !w_wr_p))
                r_prog_addr <= r_prog_addr + ADDR_W'(1);
            else if (r_state == CLEAR && r_sweep == LAST_ADDR)
                r_prog_addr <= '0;
            if (r_state == CLEAR) r_sweep <= r_sweep + ADDR_W'(1);
        end
    end

    always_comb begin
        w_addr  = cpu_addr;
        w_we    = cpu_write;
        w_wdata = cpu_data;
        case (r_state)
            MANUAL: begin
                w_addr  = r_prog_addr;
                w_we    = 1'b0;
                w_wdata = program_switches;
            end
            WRITE: begin
                w_addr  = r_prog_addr;
                w_we    = 1'b1;
                w_wdata = program_switches;
            end
            CLEAR: begin
                w_addr  = r_sweep;
                w_we    = 1'b1;
                w_wdata = '0;
            end
            default: ;
        endcase
    end

    // Gating with rst_n kills a write strobe the instant reset asserts.
    assign ram_address = w_addr;
    assign ram_write   = w_we & rst_n;
    assign ram_wdata   = w_wdata;
    assign cpu_hold    = r_cpu_hold;
    assign manual_mode = r_manual_mode;
    assign prog_addr   = r_prog_addr;
endmodule

// File: tb/tb_ram_program_controller.sv
// Random panel-operation bench for ram_program_controller against a
// transaction-level memory/program-address model.
module tb_ram_program_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_sw, step_btn, write_btn, clear_btn, cpu_boundary, cpu_write;
    logic [7:0] program_switches, cpu_data;
    logic [3:0] cpu_addr;
    logic [3:0] ram_address, prog_addr;
    logic       ram_write, cpu_hold, manual_mode;
    logic [7:0] ram_wdata;

    ram_program_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode_sw(mode_sw), .step_btn(step_btn),
        .write_btn(write_btn), .clear_btn(clear_btn),
        .program_switches(program_switches), .cpu_boundary(cpu_boundary),
        .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_data(cpu_data),
        .ram_address(ram_address), .ram_write(ram_write), .ram_wdata(ram_wdata),
        .cpu_hold(cpu_hold), .manual_mode(manual_mode), .prog_addr(prog_addr)
    );

    always #5 clk = ~clk;

    int         n_vec = 0, n_err = 0, cyc = 0, wr_cnt = 0;
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic [3:0] ref_pa;
    logic [3:0] log_a [$];
    logic [7:0] log_d [$];
    int         log_c [$];

    // The memory the controller drives; panel writes are also logged.
    always @(posedge clk) cyc++;
    always @(negedge clk) if (rst_n) begin
        if (ram_write) mem[ram_address] = ram_wdata;
        if (ram_write && cpu_hold) begin
            wr_cnt++;
            log_a.push_back(ram_address);
            log_d.push_back(ram_wdata);
            log_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // mask: bit0 step, bit1 write, bit2 clear
    task automatic press(input logic [2:0] mask, input int hi);
        step_btn = mask[0]; write_btn = mask[1]; clear_btn = mask[2];
        tick(hi);
        step_btn = 0; write_btn = 0; clear_btn = 0;
        tick(24);
    endtask

    task automatic glitch(input logic which);
        repeat (4) begin
            if (which) write_btn = 1; else step_btn = 1;
            tick(3);
            write_btn = 0; step_btn = 0;
            tick(2);
        end
        tick(20);
    endtask

    task automatic cmp_mem(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, {24'h0, mem[i]}, {24'h0, ref_mem[i]});
    endtask

    task automatic enter_manual();
        int k;
        mode_sw = 1; cpu_boundary = 1; cpu_write = 0;
        k = 0;
        while (!cpu_hold && k < 40) begin tick(1); k++; end
        chk("enter_hold", cpu_hold, 1);
        cpu_boundary = 0;
    endtask

    initial begin
        int wb, k, hmax, op;
        logic [7:0] sw;
        for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        rst_n = 0; mode_sw = 0; step_btn = 0; write_btn = 0; clear_btn = 0;
        program_switches = 0; cpu_boundary = 0;
        cpu_addr = 4'h3; cpu_write = 1; cpu_data = 8'h11;
        #12;
        chk("rst_hold", cpu_hold, 0);
        chk("rst_led", manual_mode, 0);
        chk("rst_we", ram_write, 0);
        chk("rst_pa", prog_addr, 0);
        chk("rst_addr", ram_address, 4'h3);
        chk("rst_wdata", ram_wdata, 8'h11);
        cpu_write = 0;
        tick(1); rst_n = 1; tick(2);

        // RUN passthrough, including CPU writes into the model memory
        for (int i = 0; i < 6; i++) begin
            cpu_addr = 4'($urandom); cpu_data = 8'($urandom); cpu_write = 1'($urandom);
            #1;
            chk("run_addr", ram_address, cpu_addr);
            chk("run_we", ram_write, cpu_write);
            chk("run_wd", ram_wdata, cpu_data);
            if (cpu_write) ref_mem[cpu_addr] = cpu_data;
            tick(1);
        end
        cpu_write = 0;

        // DRAIN abandoned by mode_sw=0 must never assert hold
        mode_sw = 1; hmax = 0;
        for (int i = 0; i < 20; i++) begin tick(1); if (cpu_hold) hmax = 1; end
        mode_sw = 0;
        for (int i = 0; i < 20; i++) begin tick(1); if (cpu_hold) hmax = 1; end
        chk("drain_abort_hold", hmax, 0);

        // DRAIN waits for the boundary
        mode_sw = 1; cpu_boundary = 0; tick(20);
        chk("drain_hold", cpu_hold, 0);
        chk("drain_led", manual_mode, 0);
        cpu_addr = 4'h7; #1;
        chk("drain_pass", ram_address, 4'h7);
        cpu_boundary = 1; #1;
        chk("pre_bnd_hold", cpu_hold, 0);
        tick(1);
        chk("bnd_hold", cpu_hold, 1);
        chk("bnd_led", manual_mode, 1);
        cpu_boundary = 0; cpu_write = 1; #1;
        chk("man_we_blocked", ram_write, 0);
        cpu_write = 0;
        ref_pa = 0;
        chk("man_pa0", prog_addr, 0);

        // first write
        program_switches = 8'h5F; wb = wr_cnt;
        press(3'b010, 8);
        ref_mem[0] = 8'h5F; ref_pa = 1;
        chk("w1_cnt", wr_cnt - wb, 1);
        chk("w1_addr", log_a[$], 4'h0);
        chk("w1_data", log_d[$], 8'h5F);
        chk("w1_pa", prog_addr, ref_pa);

        // 15 steps wrap to 0
        wb = wr_cnt;
        repeat (15) press(3'b001, 8);
        ref_pa = 0;
        chk("wrap_pa", prog_addr, ref_pa);
        chk("wrap_nowr", wr_cnt - wb, 0);

        // simultaneous write+step: one write, one increment
        program_switches = 8'hC4; wb = wr_cnt;
        press(3'b011, 8);
        ref_mem[ref_pa] = 8'hC4;
        chk("both_cnt", wr_cnt - wb, 1);
        chk("both_addr", log_a[$], ref_pa);
        ref_pa = ref_pa + 1;
        chk("both_pa", prog_addr, ref_pa);

        // glitches never pulse; exactly 4 stable cycles does
        wb = wr_cnt;
        glitch(1'b1); glitch(1'b0);
        chk("glitch_pa", prog_addr, ref_pa);
        chk("glitch_nowr", wr_cnt - wb, 0);
        press(3'b001, 4);
        ref_pa = ref_pa + 1;
        chk("min_press_pa", prog_addr, ref_pa);

        // random panel operations
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 3);
            sw = 8'($urandom);
            program_switches = sw; wb = wr_cnt;
            case (op)
                0: begin press(3'b001, $urandom_range(4, 10)); ref_pa = ref_pa + 1; end
                1, 3: begin
                    press(op == 1 ? 3'b010 : 3'b011, $urandom_range(4, 10));
                    ref_mem[ref_pa] = sw;
                    ref_pa = ref_pa + 1;
                end
                default: glitch(1'($urandom));
            endcase
            chk("rnd_pa", prog_addr, ref_pa);
            chk("rnd_wcnt", wr_cnt - wb, (op == 1 || op == 3) ? 1 : 0);
        end
        cmp_mem("rnd_mem");

        // clear, with a step pulse landing mid-sweep
        log_a.delete(); log_d.delete(); log_c.delete(); wb = wr_cnt;
        clear_btn = 1; tick(5);
        step_btn = 1; tick(8);
        clear_btn = 0; step_btn = 0; tick(30);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_pa = 0;
        chk("clr_cnt", wr_cnt - wb, 16);
        for (int i = 0; i < 16 && i < log_a.size(); i++) begin
            chk("clr_addr", log_a[i], i);
            chk("clr_data", log_d[i], 0);
        end
        if (log_c.size() == 16) chk("clr_consec", log_c[15] - log_c[0], 15);
        chk("clr_pa", prog_addr, ref_pa);
        cmp_mem("clr_mem");

        // mode_sw drops during CLEAR: sweep completes, then passthrough
        log_a.delete(); log_d.delete(); log_c.delete(); wb = wr_cnt;
        cpu_addr = 4'h9; cpu_write = 1; cpu_data = 8'hA3;
        clear_btn = 1; k = 0;
        while (wr_cnt == wb && k < 40) begin tick(1); k++; end
        chk("clr2_start", wr_cnt != wb, 1);
        mode_sw = 0; clear_btn = 0; k = 0;
        while (cpu_hold && k < 60) begin tick(1); k++; end
        chk("clr2_exit", cpu_hold, 0);
        chk("clr2_cnt", wr_cnt - wb, 16);
        chk("clr2_led", manual_mode, 0);
        chk("clr2_addr", ram_address, 4'h9);
        chk("clr2_we", ram_write, 1);
        chk("clr2_wd", ram_wdata, 8'hA3);
        tick(1);
        cpu_write = 0;
        ref_mem[9] = 8'hA3;
        chk("clr2_pa", prog_addr, 0);
        cmp_mem("end_mem");

        // reset in the middle of a WRITE
        enter_manual();
        press(3'b001, 6); press(3'b001, 6);
        chk("pre_rst_pa", prog_addr, 2);
        write_btn = 1; k = 0;
        while (!(ram_write && cpu_hold) && k < 30) begin tick(1); k++; end
        chk("wr_seen", ram_write, 1);
        chk("wr_addr", ram_address, 2);
        write_btn = 0; #2;
        rst_n = 0; #1;
        chk("rst_mid_we", ram_write, 0);
        chk("rst_mid_pa", prog_addr, 0);
        chk("rst_mid_hold", cpu_hold, 0);
        chk("rst_mid_led", manual_mode, 0);
        tick(2); rst_n = 1; tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_program_controller.md
# ram_program_controller

Sequencer that owns the address, write-enable and write-data inputs of the 16×8 CPU memory and shares them between the running CPU and the front-panel programming switches. It takes manual control only at a CPU instruction boundary and stalls the CPU while manual control is active. In manual mode it provides debounced step, write and clear operations with an auto-incrementing program address.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: number of consecutive stable samples required before a debounced input changes. Benches use 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode_sw  in  1  raw panel switch; 1 requests manual mode.
- step_btn  in  1  raw button; advances the program address.
- write_btn  in  1  raw button; writes program_switches, then advances.
- clear_btn  in  1  raw button; zero-fills the whole memory.
- program_switches  in  8  panel data.
- cpu_boundary  in  1  CPU is at an instruction boundary or halted.
- cpu_addr  in  4  CPU memory address.
- cpu_write  in  1  CPU memory write strobe.
- cpu_data  in  8  CPU bus data.
- ram_address  out  4  to memory address.
- ram_write  out  1  to memory write enable.
- ram_wdata  out  8  to memory write data.
- cpu_hold  out  1  stalls the CPU clock-enable.
- manual_mode  out  1  manual control is active (panel LED).
- prog_addr  out  4  current program address (panel display).

## Operation
- All four raw inputs pass through a 2-flop synchronizer and then a debouncer. Buttons produce a single-cycle rising-edge pulse. mode_sw produces a debounced level.
- States:
  - RUN: ram_* passes through from cpu_addr, cpu_write and cpu_data; cpu_hold=0. Debounced mode_sw=1 → DRAIN.
  - DRAIN: passthrough continues, cpu_hold=0. When cpu_boundary=1 → MANUAL, and cpu_hold rises in that same transition.
  - MANUAL: cpu_hold=1, ram_address=prog_addr, ram_write=0. Events are taken in priority order clear > write > step:
    - clear pulse → CLEAR.
    - write pulse → WRITE.
    - step pulse → prog_addr+1.
    - If mode_sw=0 and no pulse → RUN.
  - WRITE: one cycle. ram_write=1, ram_address=prog_addr, ram_wdata=program_switches (sampled in this cycle). prog_addr+1. Then → MANUAL.
  - CLEAR: 16 cycles. ram_address = sweep counter 0..15, ram_write=1, ram_wdata=0. Then prog_addr=0 → MANUAL.
- prog_addr is 4-bit and wraps 15→0 on increment.
- Pulses that arrive outside MANUAL are dropped, not queued. This includes pulses during WRITE or CLEAR, and pulses in RUN or DRAIN.
- mode_sw=0 while in DRAIN → RUN without asserting cpu_hold.
- mode_sw=0 during WRITE or CLEAR: the operation completes, then MANUAL exits to RUN on the next cycle.
- cpu_write in MANUAL, WRITE or CLEAR is ignored; the CPU is held and must not issue writes.

## Timing
- Reset values:
  - state=RUN.
  - prog_addr=0, sweep counter=0.
  - debouncer outputs=0.
  - cpu_hold=0, manual_mode=0, ram_write=0.
  - ram_address and ram_wdata follow the RUN passthrough of their inputs.
- Reset mid-WRITE or mid-CLEAR aborts the operation immediately. ram_write deasserts asynchronously.
- Button latency: raw edge → 2 sync cycles + DEBOUNCE_CYCLES → pulse; the action takes effect on the following edge.
- Passthrough in RUN and DRAIN is combinational, so the CPU sees zero added latency.
- DRAIN → MANUAL takes 1 cycle after cpu_boundary is sampled high. manual_mode and cpu_hold are registered and asserted together.
- WRITE is exactly 1 ram_write cycle. CLEAR is exactly 16 consecutive ram_write cycles, addresses 0,1,…,15.
- MANUAL → RUN: cpu_hold drops on the same edge that restores passthrough.

## Structure
- cpu_pkg holds:
  - ADDR_W=4, DATA_W=8, MEM_DEPTH=16.
  - The opcode constants.
  - typedef enum logic [2:0] ram_ctrl_state_t {RUN, DRAIN, MANUAL, WRITE, CLEAR}.
- Sub-module: input_debouncer (parameter DEBOUNCE_CYCLES, 2-flop sync + counter + edge pulse output). It is instantiated four times.

## Test plan
- Reset, then mode_sw=1 with cpu_boundary=0 for 10 cycles, then 1 → state stays in DRAIN with cpu_hold=0. cpu_hold=1 and manual_mode=1 one cycle after the boundary.
- In MANUAL with prog_addr=0: switches=8'h5F, write pulse → one cycle of ram_write=1, address 0, data 8'h5F. prog_addr=1.
- 15 step pulses from prog_addr=1 → prog_addr=0 (wrap). write_btn and step_btn debounced in the same cycle → exactly one write at the current address and a single increment.
- Clear pulse → 16 consecutive write cycles with addresses 0..15 and data 0, prog_addr=0. A step pulse during CLEAR is ignored.
- Button bouncing with 3-cycle glitches (DEBOUNCE_CYCLES=4) → no pulse. A 4-cycle-stable press → exactly one pulse.
- mode_sw=0 during CLEAR → all 16 writes complete, then RUN with cpu_hold=0 and passthrough of cpu_addr=9, cpu_write=1, cpu_data=8'hA3 on the same cycle. Assert rst_n low mid-WRITE → ram_write=0 immediately, prog_addr=0.
